alu_src_stage: RTL and testbench

- Pipelined producer stage for the ALU operand-B select path: captures register data, a raw immediate and the ALU-source select from decode, and presents regData / signData / mALUSel to the ALU source mux.
- Sign/zero-extends the immediate.
- Decouples decode from execute with a 2-entry valid/ready skid buffer, so execute back-pressure never drops a beat.
- Supports a synchronous flush for branch squash.

---
 rtl/alu_src_stage.sv | 108 ++++++++++
 tb/tb_alu_src_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_src_stage.sv
// ALU operand-B source stage: captures register data, extended immediate and source select,
// decoupling decode from execute through a 2-entry valid/ready skid buffer.
module alu_src_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inRegData,
  input  logic [IMM_W-1:0]  inImm,
  input  logic              inZeroExt,
  input  logic              inALUSel,
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] regData,
  output logic [DATA_W-1:0] signData,
  output logic              mALUSel,
  output logic [1:0]        level
);

  localparam int unsigned ExtW = DATA_W - IMM_W;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_reg_q, main_reg_d;
  logic [DATA_W-1:0] main_sgn_q, main_sgn_d;
  logic              main_sel_q, main_sel_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_reg_q, skid_reg_d;
  logic [DATA_W-1:0] skid_sgn_q, skid_sgn_d;
  logic              skid_sel_q, skid_sel_d;

  logic [DATA_W-1:0] ext_imm;
  logic              accept;
  logic              pop;

  assign ext_imm = {{ExtW{~inZeroExt & inImm[IMM_W-1]}}, inImm};

  // inReady depends only on registered state, so outReady never reaches it combinationally.
  assign inReady = ~skid_valid_q;
  assign accept  = inValid & inReady;
  assign pop     = main_valid_q & outReady;

  always_comb begin
    main_valid_d = main_valid_q;
    main_reg_d   = main_reg_q;
    main_sgn_d   = main_sgn_q;
    main_sel_d   = main_sel_q;
    skid_valid_d = skid_valid_q;
    skid_reg_d   = skid_reg_q;
    skid_sgn_d   = skid_sgn_q;
    skid_sel_d   = skid_sel_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || (pop && !skid_valid_q)) begin
      main_valid_d = accept;
      if (accept) begin
        main_reg_d = inRegData;
        main_sgn_d = ext_imm;
        main_sel_d = inALUSel;
      end
    end else if (pop) begin
      // Skid is full here, so inReady was low and nothing was accepted.
      main_reg_d   = skid_reg_q;
      main_sgn_d   = skid_sgn_q;
      main_sel_d   = skid_sel_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_reg_d   = inRegData;
      skid_sgn_d   = ext_imm;
      skid_sel_d   = inALUSel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_reg_q   <= '0;
      main_sgn_q   <= '0;
      main_sel_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_reg_q   <= '0;
      skid_sgn_q   <= '0;
      skid_sel_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_reg_q   <= main_reg_d;
      main_sgn_q   <= main_sgn_d;
      main_sel_q   <= main_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_reg_q   <= skid_reg_d;
      skid_sgn_q   <= skid_sgn_d;
      skid_sel_q   <= skid_sel_d;
    end
  end

  assign outValid = main_valid_q;
  assign regData  = main_reg_q;
  assign signData = main_sgn_q;
  assign mALUSel  = main_sel_q;
  assign level    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_alu_src_stage.sv
// Directed bench for alu_src_stage: streaming vector table plus stall, flush and reset sequences.
module tb_alu_src_stage;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] inRegData;
  logic [15:0] inImm;
  logic        inZeroExt;
  logic        inALUSel;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] regData;
  logic [31:0] signData;
  logic        mALUSel;
  logic [1:0]  level;

  alu_src_stage #(
    .DATA_W(32),
    .IMM_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inRegData(inRegData),
    .inImm    (inImm),
    .inZeroExt(inZeroExt),
    .inALUSel (inALUSel),
    .flush    (flush),
    .outValid (outValid),
    .outReady (outReady),
    .regData  (regData),
    .signData (signData),
    .mALUSel  (mALUSel),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] reg_d;
    logic [15:0] imm;
    logic        zext;
    logic        sel;
    logic        out_ready;
    logic        exp_ov;
    logic [31:0] exp_reg;
    logic [31:0] exp_sgn;
    logic        exp_sel;
    logic [1:0]  exp_lvl;
    logic        exp_ir;
  } vec_t;

  vec_t vecs[7];
  int   n_applied = 0;
  int   n_fail    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [31:0] rd,
                         input logic [31:0] sd, input logic sel, input logic [1:0] lvl,
                         input logic ir);
    chk({tag, ".outValid"}, {31'd0, outValid}, {31'd0, ov});
    chk({tag, ".regData"}, regData, rd);
    chk({tag, ".signData"}, signData, sd);
    chk({tag, ".mALUSel"}, {31'd0, mALUSel}, {31'd0, sel});
    chk({tag, ".level"}, {30'd0, level}, {30'd0, lvl});
    chk({tag, ".inReady"}, {31'd0, inReady}, {31'd0, ir});
  endtask

  task automatic drive(input logic v, input logic [31:0] rd, input logic [15:0] imm,
                       input logic z, input logic sel);
    inValid   = v;
    inRegData = rd;
    inImm     = imm;
    inZeroExt = z;
    inALUSel  = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          vld reg           imm       z     sel   ordy  ov    expReg        expSgn        sel   lvl   ir
    vecs[0] = '{1'b1, 32'd5000,     16'd4000, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5000,     32'h00000FA0, 1'b0, 2'd1, 1'b1};
    vecs[1] = '{1'b1, 32'd5001,     16'd4000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5001,     32'h00000FA0, 1'b1, 2'd1, 1'b1};
    vecs[2] = '{1'b1, 32'd7,        16'hF830, 1'b0, 1'b1, 1'b1, 1'b1, 32'd7,        32'hFFFFF830, 1'b1, 2'd1, 1'b1};
    vecs[3] = '{1'b1, 32'd8,        16'hF830, 1'b1, 1'b0, 1'b1, 1'b1, 32'd8,        32'h0000F830, 1'b0, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 32'd99,       16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8,        32'h0000F830, 1'b0, 2'd0, 1'b1};
    vecs[5] = '{1'b1, 32'h12345678, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'hFFFF8000, 1'b1, 2'd1, 1'b1};
    vecs[6] = '{1'b0, 32'd0,        16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'hFFFF8000, 1'b1, 2'd0, 1'b1};

    rst_n    = 1'b0;
    flush    = 1'b0;
    outReady = 1'b1;
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    #2;
    chk_out("reset", 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming table: each vector's outputs are checked one edge after it is driven.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].in_valid, vecs[i].reg_d, vecs[i].imm, vecs[i].zext, vecs[i].sel);
      outReady = vecs[i].out_ready;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_reg, vecs[i].exp_sgn,
              vecs[i].exp_sel, vecs[i].exp_lvl, vecs[i].exp_ir);
    end

    // Stall with A, B, C offered; then drain in order.
    outReady = 1'b0;
    drive(1'b1, 32'hA, 16'h0001, 1'b0, 1'b1);
    step();
    chk_out("stall.A", 1'b1, 32'hA, 32'h1, 1'b1, 2'd1, 1'b1);
    drive(1'b1, 32'hB, 16'hFFFF, 1'b0, 1'b0);
    step();
    chk_out("stall.B", 1'b1, 32'hA, 32'h1, 1'b1, 2'd2, 1'b0);
    drive(1'b1, 32'hC, 16'hFFFF, 1'b1, 1'b1);
    step();
    chk_out("stall.C1", 1'b1, 32'hA, 32'h1, 1'b1, 2'd2, 1'b0);
    step();
    chk_out("stall.C2", 1'b1, 32'hA, 32'h1, 1'b1, 2'd2, 1'b0);
    outReady = 1'b1;
    step();
    chk_out("drain.B", 1'b1, 32'hB, 32'hFFFFFFFF, 1'b0, 2'd1, 1'b1);
    step();
    chk_out("drain.C", 1'b1, 32'hC, 32'h0000FFFF, 1'b1, 2'd1, 1'b1);
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    chk_out("drain.end", 1'b0, 32'hC, 32'h0000FFFF, 1'b1, 2'd0, 1'b1);

    // Flush with two beats held, then flush over an accepted beat.
    outReady = 1'b0;
    drive(1'b1, 32'h11, 16'h0011, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 16'h0022, 1'b0, 1'b1);
    step();
    chk_out("flush.pre", 1'b1, 32'h11, 32'h11, 1'b0, 2'd2, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h33, 16'h0033, 1'b0, 1'b1);
    step();
    chk_out("flush.full", 1'b0, 32'h11, 32'h11, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 32'h44, 16'h0044, 1'b0, 1'b1);
    step();
    chk_out("flush.acc", 1'b0, 32'h11, 32'h11, 1'b0, 2'd0, 1'b1);
    flush = 1'b0;
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    outReady = 1'b1;
    step();
    chk_out("flush.post", 1'b0, 32'h11, 32'h11, 1'b0, 2'd0, 1'b1);

    // Asynchronous reset between edges with two beats held.
    outReady = 1'b0;
    drive(1'b1, 32'h55, 16'h8055, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h66, 16'h0066, 1'b0, 1'b0);
    step();
    chk_out("arst.pre", 1'b1, 32'h55, 32'hFFFF8055, 1'b1, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_out("arst.post", 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
